// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD host command path.
// Contents:
//   resp_type_t  - expected response codes latched with each command
//   status_t     - completion status reported with done
//   state_t      - command sequencer state encoding
//   RESP_WIDTH   - width of the receive-path response bus
//   timer_width  - width needed for a down-counter covering two cycle counts
// -----------------------------------------------------------------------------
package sd_pkg;

    localparam int RESP_WIDTH = 127;

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_R1   = 2'b01,
        RESP_R2   = 2'b10,
        RESP_R3   = 2'b11
    } resp_type_t;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'b00,
        STATUS_CRC_ERR = 2'b01,
        STATUS_TIMEOUT = 2'b10
    } status_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_RECV,
        ST_GAP,
        ST_DONE
    } state_t;

    // The timer is loaded with count-1, so clog2 of the larger count is enough.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sd_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// sd_cmd_ctrl_if
// Bundles the host command register signals and the sd_cmd transmit/receive
// datapath signals seen by the command sequencer.
// Modports:
//   slave  - the sequencer (accepts requests, drives tx/rx control and results)
//   master - the environment (host requester plus transmitter/receiver)
// Host side:      cmd_req, cmd_index, cmd_arg, resp_type, cmd_ack, busy, done,
//                 status, resp_data, retry_count
// Datapath side:  tx_start, tx_index, tx_arg, tx_done, receive_en,
//                 R2_response, R3_response, sd_receive_finished, crc_err,
//                 response
// -----------------------------------------------------------------------------
interface sd_cmd_ctrl_if;
    import sd_pkg::*;

    logic                  cmd_req;
    logic [5:0]            cmd_index;
    logic [31:0]           cmd_arg;
    logic [1:0]            resp_type;
    logic                  cmd_ack;
    logic                  busy;
    logic                  done;
    logic [1:0]            status;
    logic [RESP_WIDTH-1:0] resp_data;
    logic [1:0]            retry_count;

    logic                  tx_start;
    logic [5:0]            tx_index;
    logic [31:0]           tx_arg;
    logic                  tx_done;
    logic                  receive_en;
    logic                  R2_response;
    logic                  R3_response;
    logic                  sd_receive_finished;
    logic                  crc_err;
    logic [RESP_WIDTH-1:0] response;

    modport slave (
        input  cmd_req, cmd_index, cmd_arg, resp_type,
        input  tx_done, sd_receive_finished, crc_err, response,
        output cmd_ack, busy, done, status, resp_data, retry_count,
        output tx_start, tx_index, tx_arg, receive_en, R2_response, R3_response
    );

    modport master (
        output cmd_req, cmd_index, cmd_arg, resp_type,
        output tx_done, sd_receive_finished, crc_err, response,
        input  cmd_ack, busy, done, status, resp_data, retry_count,
        input  tx_start, tx_index, tx_arg, receive_en, R2_response, R3_response
    );

endinterface

// File: rtl/sd_cycle_timer.sv
// -----------------------------------------------------------------------------
// sd_cycle_timer
// Loadable down-counter with a zero flag. Load has priority over counting and
// the counter holds at zero rather than wrapping.
// Ports:
//   ex_clk, reset_n  - clock, asynchronous active-low reset
//   load, load_value - synchronous load of the start count
//   count_en         - decrement by one per cycle while non-zero
//   zero             - count is zero
// -----------------------------------------------------------------------------
module sd_cycle_timer #(
    parameter int WIDTH = 10
) (
    input  logic             ex_clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_en,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    // Count register: load wins, otherwise decrement and stick at zero.
    always_ff @(posedge ex_clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_en && (count_q != '0)) begin
            count_q <= count_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/sd_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// sd_cmd_ctrl
// Command/response sequencer for the SD host. Accepts one command at a time,
// starts the transmitter, enables and configures the response receiver,
// supervises it with a timeout and retries on CRC error or timeout. Every
// attempt is followed by an idle gap before resend or completion.
// Parameters:
//   RESP_TIMEOUT - cycles allowed in RECV before a timeout
//   GAP_CYCLES   - idle cycles after every attempt
//   MAX_RETRY    - extra attempts after the first failure (0..3)
// Ports:
//   ex_clk, reset_n - clock, asynchronous active-low reset
//   bus             - sd_cmd_ctrl_if slave view (host and datapath signals)
// -----------------------------------------------------------------------------
module sd_cmd_ctrl
    import sd_pkg::*;
#(
    parameter int RESP_TIMEOUT = 1024,
    parameter int GAP_CYCLES   = 16,
    parameter int MAX_RETRY    = 2
) (
    input  logic         ex_clk,
    input  logic         reset_n,
    sd_cmd_ctrl_if.slave bus
);

    localparam int               TIMER_W     = timer_width(RESP_TIMEOUT, GAP_CYCLES);
    localparam logic [TIMER_W-1:0] RESP_LOAD = TIMER_W'(RESP_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRY);

    state_t                state_q, state_d;
    logic [5:0]            index_q;
    logic [31:0]           arg_q;
    resp_type_t            type_q;
    logic [1:0]            retries_q;
    logic                  resend_q;
    status_t               status_q;
    logic [RESP_WIDTH-1:0] resp_data_q;

    logic                  accept;
    logic                  capture;
    logic                  fail;
    status_t               fail_code;
    logic                  gap_exit;
    logic                  timer_load;
    logic [TIMER_W-1:0]    timer_load_value;
    logic                  timer_en;
    logic                  timer_zero;

    // One shared counter: the response timeout and the gap never overlap.
    sd_cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .ex_clk     (ex_clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_load_value),
        .count_en   (timer_en),
        .zero       (timer_zero)
    );

    // State register.
    always_ff @(posedge ex_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes. The timer is reloaded with the gap count
    // on every RECV exit, so the gap starts counting in its first cycle.
    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        capture          = 1'b0;
        fail             = 1'b0;
        fail_code        = STATUS_CRC_ERR;
        gap_exit         = 1'b0;
        timer_load       = 1'b0;
        timer_load_value = GAP_LOAD;
        timer_en         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_req) begin
                    accept  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (bus.tx_done) begin
                    timer_load = 1'b1;
                    if (type_q == RESP_NONE) begin
                        timer_load_value = GAP_LOAD;
                        state_d          = ST_GAP;
                    end else begin
                        timer_load_value = RESP_LOAD;
                        state_d          = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                timer_en = 1'b1;
                // A finished response takes precedence over a same-cycle timeout.
                if (bus.sd_receive_finished) begin
                    capture          = 1'b1;
                    timer_load       = 1'b1;
                    timer_load_value = GAP_LOAD;
                    state_d          = ST_GAP;
                    // R3 carries no valid CRC, so its CRC flag is ignored.
                    if ((type_q != RESP_R3) && bus.crc_err) begin
                        fail      = 1'b1;
                        fail_code = STATUS_CRC_ERR;
                    end
                end else if (timer_zero) begin
                    fail             = 1'b1;
                    fail_code        = STATUS_TIMEOUT;
                    timer_load       = 1'b1;
                    timer_load_value = GAP_LOAD;
                    state_d          = ST_GAP;
                end
            end
            ST_GAP: begin
                timer_en = 1'b1;
                if (timer_zero) begin
                    gap_exit = 1'b1;
                    state_d  = resend_q ? ST_SEND : ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command latch, retry bookkeeping and result capture. Results are cleared
    // on accept so a new command never reports a previous outcome.
    always_ff @(posedge ex_clk or negedge reset_n) begin
        if (!reset_n) begin
            index_q     <= '0;
            arg_q       <= '0;
            type_q      <= RESP_NONE;
            retries_q   <= '0;
            resend_q    <= 1'b0;
            status_q    <= STATUS_OK;
            resp_data_q <= '0;
        end else begin
            if (accept) begin
                index_q     <= bus.cmd_index;
                arg_q       <= bus.cmd_arg;
                type_q      <= resp_type_t'(bus.resp_type);
                retries_q   <= '0;
                resend_q    <= 1'b0;
                status_q    <= STATUS_OK;
                resp_data_q <= '0;
            end
            if (capture) begin
                resp_data_q <= bus.response;
            end
            if (fail) begin
                if (retries_q < RETRY_LIMIT) begin
                    retries_q <= retries_q + 2'd1;
                    resend_q  <= 1'b1;
                end else begin
                    status_q <= fail_code;
                end
            end
            if (gap_exit) begin
                resend_q <= 1'b0;
            end
        end
    end

    // Outputs come from state and registers only; the ack is suppressed on
    // resends because retries_q is already non-zero by then.
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.tx_start    = (state_q == ST_SEND);
    assign bus.cmd_ack     = (state_q == ST_SEND) && (retries_q == 2'd0);
    assign bus.receive_en  = (state_q == ST_RECV);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.tx_index    = index_q;
    assign bus.tx_arg      = arg_q;
    assign bus.R2_response = bus.busy && (type_q == RESP_R2);
    assign bus.R3_response = bus.busy && (type_q == RESP_R3);
    assign bus.status      = status_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.retry_count = retries_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sd_cmd_ctrl
// Self-checking bench for sd_cmd_ctrl. The stimulus process issues commands
// and plays the transmitter/receiver; each command pushes its expected result
// into a scoreboard queue. A monitor on the falling edge counts tx_start,
// cmd_ack and receive_en cycles, checks the R2/R3 configuration while busy,
// and pops and compares the expected result whenever done is presented.
// -----------------------------------------------------------------------------
module tb_sd_cmd_ctrl;
    import sd_pkg::*;

    localparam int GAP = 16;
    localparam int TMO = 1024;

    typedef struct {
        logic [1:0]            status;
        logic [RESP_WIDTH-1:0] resp;
        logic [1:0]            retries;
        int                    tx_starts;
        int                    recv_cycles;
        logic                  r2;
        logic                  r3;
    } exp_t;

    logic ex_clk  = 1'b0;
    logic reset_n = 1'b0;

    exp_t sb[$];
    exp_t mon_e;
    int   checks         = 0;
    int   failures       = 0;
    int   cyc            = 0;
    int   last_event_cyc = 0;
    int   n_start        = 0;
    int   n_ack          = 0;
    int   n_recv         = 0;
    int   n_r2_bad       = 0;
    int   n_r3_bad       = 0;

    always #5 ex_clk = ~ex_clk;

    always @(posedge ex_clk) cyc <= cyc + 1;

    sd_cmd_ctrl_if bus ();

    sd_cmd_ctrl #(
        .RESP_TIMEOUT (TMO),
        .GAP_CYCLES   (GAP),
        .MAX_RETRY    (2)
    ) dut (
        .ex_clk  (ex_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check_int(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_wide(input string name, input logic [RESP_WIDTH-1:0] actual,
                              input logic [RESP_WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic exp_t mk_exp(input logic [1:0] st, input logic [RESP_WIDTH-1:0] rd,
                                    input logic [1:0] rc, input int ns, input int nr,
                                    input logic r2, input logic r3);
        exp_t e;
        e.status      = st;
        e.resp        = rd;
        e.retries     = rc;
        e.tx_starts   = ns;
        e.recv_cycles = nr;
        e.r2          = r2;
        e.r3          = r3;
        return e;
    endfunction

    function automatic logic [RESP_WIDTH-1:0] make_resp(input logic [31:0] seed);
        logic [127:0] w;
        w = {seed, ~seed, seed ^ 32'h5A5A_5A5A, seed};
        return w[RESP_WIDTH-1:0];
    endfunction

    // Monitor: per-command counters are cleared after each done and in reset.
    always @(negedge ex_clk) begin
        if (!reset_n) begin
            n_start  = 0;
            n_ack    = 0;
            n_recv   = 0;
            n_r2_bad = 0;
            n_r3_bad = 0;
        end else begin
            if (bus.tx_start) n_start++;
            if (bus.cmd_ack) n_ack++;
            if (bus.receive_en) n_recv++;
            if (bus.busy && (sb.size() > 0)) begin
                if (bus.R2_response !== sb[0].r2) n_r2_bad++;
                if (bus.R3_response !== sb[0].r3) n_r3_bad++;
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL done_unexpected: done with empty scoreboard at cycle %0d", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check_int("status", int'(bus.status), int'(mon_e.status));
                    check_wide("resp_data", bus.resp_data, mon_e.resp);
                    check_int("retry_count", int'(bus.retry_count), int'(mon_e.retries));
                    check_int("tx_start_pulses", n_start, mon_e.tx_starts);
                    check_int("cmd_ack_pulses", n_ack, 1);
                    check_int("receive_en_cycles", n_recv, mon_e.recv_cycles);
                    check_int("r2_config_bad_cycles", n_r2_bad, 0);
                    check_int("r3_config_bad_cycles", n_r3_bad, 0);
                    check_int("done_cycle", cyc, last_event_cyc + GAP + 1);
                    check_int("busy_at_done", int'(bus.busy), 1);
                end
                n_start  = 0;
                n_ack    = 0;
                n_recv   = 0;
                n_r2_bad = 0;
                n_r3_bad = 0;
            end
        end
    end

    // Issue a command from an idle DUT; ack and tx_start must follow next cycle.
    task automatic apply_stimulus(input logic [5:0] idx, input logic [31:0] arg,
                                  input logic [1:0] rtype, input exp_t e);
        sb.push_back(e);
        bus.cmd_index = idx;
        bus.cmd_arg   = arg;
        bus.resp_type = rtype;
        bus.cmd_req   = 1'b1;
        @(negedge ex_clk);
        check_int("accept_cmd_ack", int'(bus.cmd_ack), 1);
        check_int("accept_tx_start", int'(bus.tx_start), 1);
        check_int("tx_index", int'(bus.tx_index), int'(idx));
        check_int("tx_arg", int'(bus.tx_arg), int'(arg));
        bus.cmd_req   = 1'b0;
        bus.cmd_index = '0;
        bus.cmd_arg   = '0;
        bus.resp_type = '0;
    endtask

    // One attempt: wait for tx_start, pulse tx_done after tx_delay cycles, then
    // finish the response resp_delay cycles into RECV (0: no response phase,
    // negative: receiver stays silent). ev is the cycle the attempt resolved.
    task automatic run_attempt(input int exp_start, input int tx_delay, input int resp_delay,
                               input logic crc, input logic [RESP_WIDTH-1:0] resp, output int ev);
        int n;
        int t;
        n = 0;
        while ((bus.tx_start !== 1'b1) && (n < 3000)) begin
            @(negedge ex_clk);
            n++;
        end
        check_int("tx_start_seen", int'(bus.tx_start), 1);
        if (exp_start >= 0) check_int("tx_start_cycle", cyc, exp_start);
        repeat (tx_delay) @(negedge ex_clk);
        bus.tx_done = 1'b1;
        t = cyc;
        @(negedge ex_clk);
        bus.tx_done = 1'b0;
        if (resp_delay == 0) begin
            ev = t;
        end else if (resp_delay < 0) begin
            ev = t + TMO;
        end else begin
            repeat (resp_delay - 1) @(negedge ex_clk);
            bus.crc_err             = crc;
            bus.response            = resp;
            bus.sd_receive_finished = 1'b1;
            ev = cyc;
            @(negedge ex_clk);
            bus.sd_receive_finished = 1'b0;
            bus.crc_err             = 1'b0;
            bus.response            = '0;
        end
        last_event_cyc = ev;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((bus.done !== 1'b1) && (n < 3000)) begin
            @(negedge ex_clk);
            n++;
        end
        check_int("done_seen", int'(bus.done), 1);
        @(negedge ex_clk);
        check_int("idle_after_done", int'(bus.busy), 0);
    endtask

    initial begin
        logic [127:0]          wide;
        logic [RESP_WIDTH-1:0] r_fill, r_a, r_b, r_c;
        int                    ev;

        wide   = {32{4'h1}};
        r_fill = wide[RESP_WIDTH-1:0];
        r_a    = make_resp(32'hA5C3_0001);
        r_b    = make_resp(32'h3C5A_0002);
        r_c    = make_resp(32'h0F1E_0003);

        bus.cmd_req             = 1'b0;
        bus.cmd_index           = '0;
        bus.cmd_arg             = '0;
        bus.resp_type           = '0;
        bus.tx_done             = 1'b0;
        bus.sd_receive_finished = 1'b0;
        bus.crc_err             = 1'b0;
        bus.response            = '0;

        reset_n = 1'b0;
        repeat (3) @(negedge ex_clk);
        check_int("rst_busy", int'(bus.busy), 0);
        check_int("rst_tx_start", int'(bus.tx_start), 0);
        check_int("rst_done", int'(bus.done), 0);
        check_int("rst_status", int'(bus.status), 0);
        check_wide("rst_resp_data", bus.resp_data, '0);
        reset_n = 1'b1;
        @(negedge ex_clk);

        $display("[TB] CMD0, no response");
        apply_stimulus(6'd0, 32'h0, 2'b00, mk_exp(2'b00, '0, 2'd0, 1, 0, 1'b0, 1'b0));
        run_attempt(-1, 40, 0, 1'b0, '0, ev);
        wait_done();

        $display("[TB] CMD17, R1 clean");
        apply_stimulus(6'd17, 32'h0000_0200, 2'b01, mk_exp(2'b00, r_fill, 2'd0, 1, 5, 1'b0, 1'b0));
        run_attempt(-1, 8, 5, 1'b0, r_fill, ev);
        wait_done();

        $display("[TB] CMD2, R2 with two CRC retries");
        apply_stimulus(6'd2, 32'h0, 2'b10, mk_exp(2'b00, r_c, 2'd2, 3, 12, 1'b1, 1'b0));
        run_attempt(-1, 6, 4, 1'b1, r_a, ev);
        run_attempt(ev + GAP + 1, 6, 4, 1'b1, r_b, ev);
        run_attempt(ev + GAP + 1, 6, 4, 1'b0, r_c, ev);
        wait_done();

        $display("[TB] ACMD41, R3 ignores CRC");
        apply_stimulus(6'd41, 32'h40FF_8000, 2'b11, mk_exp(2'b00, r_b, 2'd0, 1, 3, 1'b0, 1'b1));
        run_attempt(-1, 5, 3, 1'b1, r_b, ev);
        wait_done();

        $display("[TB] CMD13, receiver silent");
        apply_stimulus(6'd13, 32'h1234_0000, 2'b01, mk_exp(2'b10, '0, 2'd2, 3, 3 * TMO, 1'b0, 1'b0));
        run_attempt(-1, 4, -1, 1'b0, '0, ev);
        run_attempt(ev + GAP + 1, 4, -1, 1'b0, '0, ev);
        run_attempt(ev + GAP + 1, 4, -1, 1'b0, '0, ev);
        wait_done();

        $display("[TB] CMD17, CRC error on every attempt");
        apply_stimulus(6'd17, 32'h0000_0400, 2'b01, mk_exp(2'b01, r_c, 2'd2, 3, 6, 1'b0, 1'b0));
        run_attempt(-1, 3, 2, 1'b1, r_a, ev);
        run_attempt(ev + GAP + 1, 3, 2, 1'b1, r_b, ev);
        run_attempt(ev + GAP + 1, 3, 2, 1'b1, r_c, ev);
        wait_done();

        $display("[TB] CMD18, finished on the timeout cycle");
        apply_stimulus(6'd18, 32'h0000_0600, 2'b01, mk_exp(2'b00, r_a, 2'd0, 1, TMO, 1'b0, 1'b0));
        run_attempt(-1, 4, TMO, 1'b0, r_a, ev);
        wait_done();

        $display("[TB] CMD55 R2, reset during second RECV");
        apply_stimulus(6'd55, 32'hDEAD_BEEF, 2'b10, mk_exp(2'b00, '0, 2'd0, 0, 0, 1'b1, 1'b0));
        run_attempt(-1, 4, 3, 1'b1, r_b, ev);
        run_attempt(ev + GAP + 1, 4, -1, 1'b0, '0, ev);
        repeat (5) @(negedge ex_clk);
        check_int("pre_reset_receive_en", int'(bus.receive_en), 1);
        check_int("pre_reset_retry_count", int'(bus.retry_count), 1);
        reset_n = 1'b0;
        sb.delete();
        @(negedge ex_clk);
        check_int("mid_rst_busy", int'(bus.busy), 0);
        check_int("mid_rst_receive_en", int'(bus.receive_en), 0);
        check_int("mid_rst_R2", int'(bus.R2_response), 0);
        check_int("mid_rst_tx_index", int'(bus.tx_index), 0);
        check_int("mid_rst_tx_arg", int'(bus.tx_arg), 0);
        check_int("mid_rst_retry_count", int'(bus.retry_count), 0);
        check_wide("mid_rst_resp_data", bus.resp_data, '0);
        @(negedge ex_clk);
        reset_n = 1'b1;
        @(negedge ex_clk);

        $display("[TB] CMD8 after reset");
        apply_stimulus(6'd8, 32'h0000_01AA, 2'b01, mk_exp(2'b00, r_c, 2'd0, 1, 2, 1'b0, 1'b0));
        run_attempt(-1, 3, 2, 1'b0, r_c, ev);
        wait_done();

        check_int("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: run exceeded time limit, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
